// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake with a 2-entry skid buffer,
// stall/flush, and zeroed control on bubbles. Define PIPE_STAGE_STATS_EN for counters.
module pipe_stage_reg #(
  parameter int                 DATA_W   = 64,
  parameter int                 CTRL_W   = 16,
  parameter logic [DATA_W-1:0]  DATA_RST = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              stall,
  input  logic              flush,
`ifdef PIPE_STAGE_STATS_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       flush_cnt,
`endif
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;

  state_t            state;
  logic              valid_q, ready_q;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              in_fire, out_fire;

  assign in_ready  = ready_q & ~stall;
  assign out_valid = valid_q & ~stall;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign occupancy = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      main_data <= DATA_RST;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      // Flush outranks stall and any same-cycle transfer.
      state     <= EMPTY;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      main_data <= DATA_RST;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (!stall) begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
            valid_q   <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
          end else if (in_fire) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
            ready_q   <= 1'b0;
            state     <= FULL;
          end else if (out_fire) begin
            // Bubble: data left as-is, control zeroed so nothing downstream writes.
            main_ctrl <= '0;
            valid_q   <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
            ready_q   <= 1'b1;
            state     <= BUSY;
          end
        end
        default: begin
          state     <= EMPTY;
          valid_q   <= 1'b0;
          ready_q   <= 1'b1;
          main_ctrl <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (stall && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + 32'd1;
      if (out_ready && !valid_q && !stall && bubble_cnt != CNT_MAX)
        bubble_cnt <= bubble_cnt + 32'd1;
      if (flush && flush_cnt != CNT_MAX)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, backpressure, stall,
// flush, flush+stall and asynchronous reset while full.
module tb_pipe_stage_reg;
  localparam int          DATA_W = 64;
  localparam int          CTRL_W = 16;
  localparam logic [63:0] RSTV   = 64'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_ready, out_valid, out_ready, stall, flush;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [1:0]        occupancy;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0]       stall_cnt, bubble_cnt, flush_cnt;
  logic [31:0]       sc0, fc0;
`endif

  int total = 0;
  int bad   = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DATA_RST(RSTV)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .stall(stall), .flush(flush),
`ifdef PIPE_STAGE_STATS_EN
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
`endif
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d, input logic [15:0] c);
    in_valid = 1'b1; in_data = d; in_ctrl = c;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle_regs(input string tag);
    chk({tag, "_ov"},  out_valid, 0);
    chk({tag, "_oc"},  out_ctrl,  0);
    chk({tag, "_od"},  out_data,  RSTV);
    chk({tag, "_ir"},  in_ready,  1);
    chk({tag, "_occ"}, occupancy, 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 0; in_data = '0; in_ctrl = '0;
    out_ready = 0; stall = 0; flush = 0;
    #12;
    idle_regs("rst");
    reset = 1'b0;
    tick();
    idle_regs("idle");

    // Streaming 1..8 with out_ready high
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 64'(i); in_ctrl = 16'(16'h100 + i);
      tick();
      chk("str_ov",   out_valid, 1);
      chk("str_od",   out_data,  64'(i));
      chk("str_oc",   out_ctrl,  64'(16'h100 + i));
      chk("str_occ",  occupancy, 1);
      chk("str_ir",   in_ready,  1);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_occ", occupancy, 0);
    chk("drain_ov",  out_valid, 0);
    chk("drain_oc",  out_ctrl,  0);

    // Backpressure: A, B fill; C held off
    out_ready = 1'b0;
    push(64'h11, 16'hA1);
    chk("bp_a_occ", occupancy, 1);
    push(64'h22, 16'hB2);
    chk("bp_b_occ", occupancy, 2);
    chk("bp_b_ir",  in_ready,  0);
    in_valid = 1'b1; in_data = 64'h33; in_ctrl = 16'hC3;
    tick();
    chk("bp_c_occ", occupancy, 2);
    chk("bp_hold_od", out_data, 64'h11);
    out_ready = 1'b1;
    #1;
    chk("bp_outA_ov", out_valid, 1);
    chk("bp_outA_od", out_data,  64'h11);
    tick();
    chk("bp_outB_od", out_data,  64'h22);
    chk("bp_outB_oc", out_ctrl,  64'hB2);
    chk("bp_outB_occ", occupancy, 1);
    chk("bp_outB_ir", in_ready,  1);
    tick();
    in_valid = 1'b0;
    chk("bp_outC_od", out_data,  64'h33);
    chk("bp_outC_oc", out_ctrl,  64'hC3);
    tick();
    chk("bp_empty_occ", occupancy, 0);

    // Stall with one word held
    out_ready = 1'b0;
    push(64'h33, 16'hD3);
    chk("st_occ", occupancy, 1);
    stall = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 64'h44; in_ctrl = 16'hE4;
    #1;
    chk("st_ov", out_valid, 0);
    chk("st_ir", in_ready,  0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_hold_occ", occupancy, 1);
      chk("st_hold_od",  out_data,  64'h33);
    end
    stall = 1'b0; in_valid = 1'b0;
    #1;
    chk("st_rel_ov", out_valid, 1);
    chk("st_rel_od", out_data,  64'h33);
    tick();
    chk("st_rel_occ", occupancy, 0);

    // Flush while full with a same-cycle input word
    out_ready = 1'b0;
    push(64'h55, 16'h55);
    push(64'h66, 16'h66);
    chk("fl_pre_occ", occupancy, 2);
    flush = 1'b1; in_valid = 1'b1; in_data = 64'h77; in_ctrl = 16'h77;
    #1;
    chk("fl_pre_ov", out_valid, 1);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    idle_regs("fl");
    tick();
    chk("fl_after_occ", occupancy, 0);
    chk("fl_after_ov",  out_valid, 0);

    // Flush and stall together
    out_ready = 1'b0;
    push(64'h88, 16'h88);
    chk("fs_pre_occ", occupancy, 1);
`ifdef PIPE_STAGE_STATS_EN
    sc0 = stall_cnt; fc0 = flush_cnt;
`endif
    flush = 1'b1; stall = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0;
    chk("fs_occ", occupancy, 0);
    chk("fs_od",  out_data,  RSTV);
    chk("fs_oc",  out_ctrl,  0);
`ifdef PIPE_STAGE_STATS_EN
    chk("fs_stall_cnt", stall_cnt, 64'(sc0 + 32'd1));
    chk("fs_flush_cnt", flush_cnt, 64'(fc0 + 32'd1));
`endif

    // Asynchronous reset while full
    push(64'h99, 16'h99);
    push(64'hAA, 16'hAA);
    chk("ar_pre_occ", occupancy, 2);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_ov",  out_valid, 0);
    chk("ar_oc",  out_ctrl,  0);
    chk("ar_od",  out_data,  RSTV);
    chk("ar_ir",  in_ready,  1);
    chk("ar_occ", occupancy, 0);
`ifdef PIPE_STAGE_STATS_EN
    chk("ar_stall_cnt", stall_cnt, 0);
    chk("ar_flush_cnt", flush_cnt, 0);
`endif
    #3;
    reset = 1'b0;
    tick();
    idle_regs("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
